// File: rtl/smem_pkg.sv
// Shared definitions for the SMEM store unit: geometry, entry layout and
// the drain state machine encoding.
package smem_pkg;

  localparam int ADDR_W     = 7;
  localparam int DEPTH      = 128;
  localparam int FIELD_W    = 64;
  localparam int ENTRY_W    = 256;
  localparam int READ_NUM_W = 9;

  // Drain controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } smem_state_e;

  // One stored entry; the first member lands in the most significant bits,
  // so the packed image is {x_info, x_2, x_1, x_0}.
  typedef struct packed {
    logic [FIELD_W-1:0] x_info;
    logic [FIELD_W-1:0] x_2;
    logic [FIELD_W-1:0] x_1;
    logic [FIELD_W-1:0] x_0;
  } smem_entry_t;

  // Builds an entry from its four fields.
  function automatic smem_entry_t pack_entry(input logic [FIELD_W-1:0] x0,
                                             input logic [FIELD_W-1:0] x1,
                                             input logic [FIELD_W-1:0] x2,
                                             input logic [FIELD_W-1:0] info);
    smem_entry_t e;
    e.x_0    = x0;
    e.x_1    = x1;
    e.x_2    = x2;
    e.x_info = info;
    return e;
  endfunction

endpackage

// File: rtl/smem_entry_ram.sv
// 128 x 256 entry store: one write port, one read port, registered read data
// with write-first bypass when both ports hit the same address.
module smem_entry_ram
  import smem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] rdata_q;

  // Array write port.
  // NOTE: the storage array has no reset; clearing 128 wide words is never
  // needed functionally and a reset would keep it out of block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read with write-first bypass; data holds when no read is issued.
  // NOTE: non-blocking assignments mean a same-edge read of mem_q sees the old
  // word, so the bypass mux is what delivers the freshly written data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/smem_store_unit.sv
// SMEM store unit: a current-interval bank with a 1-cycle read port and an
// SMEM result bank that is streamed out under valid/ready flow control.
module smem_store_unit
  import smem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  // Current-interval bank write
  input  logic                  store_valid_curr,
  input  logic [FIELD_W-1:0]    curr_x_0,
  input  logic [FIELD_W-1:0]    curr_x_1,
  input  logic [FIELD_W-1:0]    curr_x_2,
  input  logic [FIELD_W-1:0]    curr_x_info,
  input  logic [ADDR_W-1:0]     curr_x_addr,
  // SMEM bank write
  input  logic                  store_valid_mem,
  input  logic [FIELD_W-1:0]    mem_x_0,
  input  logic [FIELD_W-1:0]    mem_x_1,
  input  logic [FIELD_W-1:0]    mem_x_2,
  input  logic [FIELD_W-1:0]    mem_x_info,
  input  logic [ADDR_W-1:0]     mem_x_addr,
  // Current-interval bank read
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     current_rd_addr,
  output logic                  rd_valid,
  output logic [FIELD_W-1:0]    rd_x_0,
  output logic [FIELD_W-1:0]    rd_x_1,
  output logic [FIELD_W-1:0]    rd_x_2,
  output logic [FIELD_W-1:0]    rd_x_info,
  // SMEM drain stream
  input  logic                  drain_start,
  input  logic [ADDR_W-1:0]     drain_count,
  input  logic [READ_NUM_W-1:0] read_num,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FIELD_W-1:0]    out_x_0,
  output logic [FIELD_W-1:0]    out_x_1,
  output logic [FIELD_W-1:0]    out_x_2,
  output logic [FIELD_W-1:0]    out_x_info,
  output logic [READ_NUM_W-1:0] out_read_num,
  output logic                  out_last,
  output logic                  drain_done,
  output logic                  busy,
  output logic                  wr_conflict
);

  smem_state_e             state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;     // index of the entry on out_x_*
  logic [ADDR_W-1:0]       cnt_q, cnt_d;     // entries in the current drain
  logic [READ_NUM_W-1:0]   tag_q, tag_d;
  logic                    rd_valid_q;
  logic                    conflict_q;

  logic                    curr_we;
  logic                    mem_we;
  logic                    mem_re;
  logic [ADDR_W-1:0]       mem_raddr;
  logic                    last_beat;
  smem_entry_t             curr_wdata, mem_wdata;
  smem_entry_t             curr_rdata, mem_rdata;

  assign curr_wdata = pack_entry(curr_x_0, curr_x_1, curr_x_2, curr_x_info);
  assign mem_wdata  = pack_entry(mem_x_0, mem_x_1, mem_x_2, mem_x_info);

  // Stall drops writes to both banks; SMEM writes are also refused while a
  // drain owns the bank so the streamed image stays consistent.
  assign busy    = (state_q != ST_IDLE);
  assign curr_we = store_valid_curr & ~stall;
  assign mem_we  = store_valid_mem & ~stall & ~busy;

  smem_entry_ram u_curr_ram (
    .clk     (clk),
    .rst_n   (rst),
    .we_i    (curr_we),
    .waddr_i (curr_x_addr),
    .wdata_i (curr_wdata),
    .re_i    (rd_en),
    .raddr_i (current_rd_addr),
    .rdata_o (curr_rdata)
  );

  // The SMEM read register doubles as the stream output register: it only
  // advances when a new entry is fetched, so it holds steady under backpressure.
  smem_entry_ram u_mem_ram (
    .clk     (clk),
    .rst_n   (rst),
    .we_i    (mem_we),
    .waddr_i (mem_x_addr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // The presented entry is the final one of this drain.
  assign last_beat = (ptr_q == (cnt_q - ADDR_W'(1)));

  // Next-state and fetch control for the drain controller.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    mem_re    = 1'b0;
    mem_raddr = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          cnt_d = drain_count;
          tag_d = read_num;
          ptr_d = '0;
          if (drain_count != '0) begin
            // Fetch entry 0 now so it is presented on the first DRAIN cycle.
            state_d   = ST_DRAIN;
            mem_re    = 1'b1;
            mem_raddr = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (last_beat) begin
            state_d = ST_DONE;
          end else begin
            // Fetch the next entry on the accepting edge: no bubble.
            ptr_d     = ptr_q + ADDR_W'(1);
            mem_re    = 1'b1;
            mem_raddr = ptr_q + ADDR_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Drain controller registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
    end
  end

  // Read-valid pipeline and the sticky write-conflict flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      conflict_q <= conflict_q | (store_valid_mem & ~stall & busy);
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_x_0       = curr_rdata.x_0;
  assign rd_x_1       = curr_rdata.x_1;
  assign rd_x_2       = curr_rdata.x_2;
  assign rd_x_info    = curr_rdata.x_info;

  assign out_valid    = (state_q == ST_DRAIN);
  assign out_last     = out_valid & last_beat;
  assign out_x_0      = mem_rdata.x_0;
  assign out_x_1      = mem_rdata.x_1;
  assign out_x_2      = mem_rdata.x_2;
  assign out_x_info   = mem_rdata.x_info;
  assign out_read_num = tag_q;
  assign drain_done   = (state_q == ST_DONE);
  assign wr_conflict  = conflict_q;

endmodule

// File: doc/smem_store_unit.md
SMEM_STORE_UNIT -- requirements
Module: smem_store_unit

Interface
REQ-001 clk  in  1  single clock; all state on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 stall  in  1  pipeline stall; 1 = all array writes ignored this cycle.
REQ-004 store_valid_curr  in  1  write strobe, current-interval bank.
REQ-005 curr_x_0, curr_x_1, curr_x_2, curr_x_info  in  64 each  current-interval entry fields.
REQ-006 curr_x_addr  in  7  current-interval write address.
REQ-007 store_valid_mem  in  1  write strobe, SMEM result bank.
REQ-008 mem_x_0, mem_x_1, mem_x_2, mem_x_info  in  64 each  SMEM entry fields.
REQ-009 mem_x_addr  in  7  SMEM write address.
REQ-010 rd_en  in  1  current-bank read request.
REQ-011 current_rd_addr  in  7  current-bank read address.
REQ-012 rd_valid  out  1  read data valid, one cycle after rd_en.
REQ-013 rd_x_0, rd_x_1, rd_x_2, rd_x_info  out  64 each  current-bank read data.
REQ-014 drain_start  in  1  one-cycle pulse; begins streaming the SMEM bank.
REQ-015 drain_count  in  7  number of SMEM entries to stream; sampled on drain_start.
REQ-016 read_num  in  9  read tag; sampled on drain_start.
REQ-017 out_valid  out  1  SMEM stream valid.
REQ-018 out_ready  in  1  SMEM stream ready from the consumer.
REQ-019 out_x_0, out_x_1, out_x_2, out_x_info  out  64 each  streamed SMEM entry.
REQ-020 out_read_num  out  9  tag of the streamed entry.
REQ-021 out_last  out  1  marks the final streamed entry.
REQ-022 drain_done  out  1  one-cycle pulse when a drain completes.
REQ-023 busy  out  1  1 while the FSM is not IDLE.
REQ-024 wr_conflict  out  1  sticky error flag.

Function
REQ-025 Each bank is 128 entries x 256 bits, packed as {x_info, x_2, x_1, x_0}.
REQ-026 Write rule: a bank is written when its store_valid is 1 and stall is 0; a stalled write is dropped.
REQ-027 Curr read latency is 1 cycle; rd_valid = rd_en delayed by one cycle; rd_x_* hold their value when rd_valid is 0.
REQ-028 Read and write to the same curr address in the same cycle return the new (write-first) data.
REQ-029 FSM states: IDLE, DRAIN, DONE.
REQ-030 IDLE to DRAIN on drain_start when drain_count != 0; IDLE to DONE on drain_start when drain_count == 0; drain_start is ignored outside IDLE.
REQ-031 In DRAIN, entries 0 .. drain_count-1 stream in ascending order, each transferred on a cycle with out_valid && out_ready.
REQ-032 While out_valid = 1 and out_ready = 0, out_* are held stable.
REQ-033 No bubbles are inserted when out_ready is held at 1: after the first entry, throughput is 1 entry per cycle.
REQ-034 out_last = 1 only with entry drain_count-1; that transfer moves the FSM to DONE.
REQ-035 DONE asserts drain_done for exactly one cycle, then returns to IDLE.
REQ-036 A SMEM-bank write while busy = 1 is dropped and sets wr_conflict; wr_conflict stays 1 until reset. Curr-bank writes are unaffected by busy.
REQ-037 Address arithmetic is 7-bit; drain_count = 127 streams entries 0..126 with no wrap-around.

Reset
REQ-038 On rst = 0, immediately: FSM = IDLE; rd_valid, out_valid, out_last, drain_done, busy and wr_conflict = 0; rd_x_*, out_x_* and out_read_num = 0.
REQ-039 Array contents are not reset.
REQ-040 Reset during DRAIN aborts the stream with no drain_done pulse.

Structure
REQ-041 Shared package smem_pkg holds: ADDR_W = 7, DEPTH = 128, FIELD_W = 64, ENTRY_W = 256, READ_NUM_W = 9, and the FSM state encoding.
REQ-042 One sub-module, smem_entry_ram (128x256, 1 write / 1 read, 1-cycle read latency, write-first bypass), is instantiated twice: curr bank and SMEM bank.

Verification
REQ-043 Write curr addr 5 = {x0=1, x1=2, x2=3, info=4}, then rd_en at addr 5 -> next cycle rd_valid = 1 and rd_x = 1/2/3/4.
REQ-044 Same-cycle write and read of curr addr 9 with x2 = 0xAA -> rd_x_2 = 0xAA; a second write of 9 with stall = 1 -> the array still holds 0xAA.
REQ-045 Write SMEM entries 0..2, drain_start with count = 3 and read_num = 17, out_ready = 1 -> 3 consecutive beats, out_read_num = 17, out_last on beat 3, drain_done one cycle later.
REQ-046 Drain with count = 3 and out_ready toggling 1,0,0,1,... -> outputs stable while stalled, all 3 entries delivered in order.
REQ-047 drain_start with count = 0 -> no out_valid, drain_done one cycle later; a SMEM write during DRAIN -> wr_conflict = 1 and the entry is unchanged.
REQ-048 rst asserted mid-drain after 1 of 4 beats -> out_valid = 0 immediately, no drain_done, busy = 0.
